matrix_reader: RTL and testbench
================================

# matrix_reader

Streams one stored matrix out of the matrix storage BRAM. Given a matrix ID, the block fetches the 3-word header (dimensions and name) and then the row-major element payload through the storage manager's read port (`read_addr` / `data_out`, 1-cycle read latency). It delivers elements on a valid/ready stream with backpressure and a last marker. It is the consumer stage between the storage manager and the compute and display datapaths.

## Interface
Parameters:
- `BLOCK_SIZE`, 1152: words per matrix slot; slot base address = `matrix_id * BLOCK_SIZE`.
- `DATA_WIDTH`, 32: BRAM word width.
- `ADDR_WIDTH`, 14: BRAM address width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `read_request`  in  1  start pulse; sampled only while `read_ready`=1.
- `matrix_id`  in  3  slot to read; captured with `read_request`.
- `read_ready`  out  1  high in IDLE.
- `read_addr`  out  ADDR_WIDTH  to storage manager read address.
- `bram_dout`  in  DATA_WIDTH  from storage manager `data_out`; valid 1 cycle after address.
- `actual_rows`, `actual_cols`  out  8 each  captured header dimensions.
- `matrix_name`  out  8×8 bytes  captured name, byte 0 first.
- `meta_valid`  out  1  header fields valid; held until the next accepted request or reset.
- `data_out`  out  DATA_WIDTH  element.
- `data_valid`  out  1  element present.
- `data_ready`  in  1  downstream accepts; transfer occurs on `data_valid & data_ready`.
- `data_last`  out  1  qualifies the final element.
- `read_done`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse when a header is rejected.

## Operation
- Slot layout (fixed, shared with the writer):
  - word 0 = {16'b0, rows[15:8], cols[7:0]}.
  - words 1–2 hold name bytes 0–3 and 4–7, with byte 0 in bits [31:24].
  - elements start at word 3, row-major.
- States: IDLE → HDR → CHECK → STREAM → DONE → IDLE.
- IDLE: `read_addr` = 0. On `read_request`, capture `matrix_id`, clear `meta_valid`, go to HDR.
- HDR: issue base+0, base+1, base+2 on consecutive cycles and capture each word one cycle later. Go to CHECK after the third capture.
- CHECK (1 cycle): compute `total = rows*cols` in 16 bits.
  - If `total == 0` or `total > BLOCK_SIZE-3`: pulse `error` and return to IDLE; `meta_valid` is set regardless.
  - Otherwise set `meta_valid` and go to STREAM.
- STREAM:
  - Issue base+3+k for k = 0..total-1.
  - A new address is issued only when (FIFO occupancy + reads in flight − pop this cycle) < 2, so the 2-entry FIFO can never overflow.
  - `data_valid` = FIFO non-empty. `data_last` = 1 when the head element index == total−1.
- DONE: entered on the transfer of the last element. Pulse `read_done` for one cycle, then go to IDLE.
- Counters: issue index and pop index are 16 bits each; no wrap is possible because `total` ≤ 1149.
- `read_request` outside IDLE is ignored.
- Changes to `matrix_id` after capture have no effect.
- Priority vs writer/clearer: the storage manager grants writes over reads. System control must not start a write or clear while `read_ready`=0; under that rule the block does no collision detection.

## Timing
- Reset values:
  - `read_ready`=1; `read_addr`=0.
  - `meta_valid`, `data_valid`, `data_last`, `read_done`, `error` = 0.
  - `actual_rows`, `actual_cols`, `matrix_name`, `data_out` = 0.
  - FIFO empty; state IDLE.
- Request accepted at edge E0. Addresses base+0..2 are driven during cycles E0+1..E0+3, and `meta_valid` rises at E0+5.
- First address base+3 is driven at E0+5. First `data_valid` appears at E0+6.
- With `data_ready` held high, one element transfers per cycle with no bubbles. An N-element matrix finishes at E0+5+N. `read_done` pulses on the following cycle, and `read_ready` returns 1 one cycle after that.
- With `data_ready`=0, `data_out`, `data_valid` and `data_last` hold stable. At most 2 elements are buffered.
- `rst` mid-operation: all state returns to IDLE immediately, the FIFO is flushed, and no `read_done` is produced.

## Structure
- Shared package `matrix_storage_pkg`:
  - `HEADER_WORDS`=3 and the header field offsets/bit positions (also used by `matrix_writer`).
  - State enum `reader_state_t`.
- Sub-module `reader_skid_fifo`: 2-entry DATA_WIDTH+1 (data plus last flag) FIFO with push/pop/count. The reader FSM, address generator and header capture stay in `matrix_reader`.

## Test plan
- Slot 2 holds a 2×3 matrix, name "MATA", elements 1..6; `data_ready`=1.
  - Required: `actual_rows`=2, `actual_cols`=3, `meta_valid` at E0+5.
  - Elements 1..6 on consecutive cycles starting E0+6, `data_last` on 6, `read_done` at E0+12.
- Same matrix, `data_ready` toggling 1,0,0,1,…: all 6 values in order with none lost or duplicated; outputs stable while stalled; no read address beyond base+8.
- Slot 0 holds a 0×5 header: `error` pulses one cycle after header capture, `data_valid` never rises, `read_ready` returns high.
- Slot 7 holds a 34×34 header (total 1156 > 1149): `error` pulses; no address above 7*1152+2 is issued.
- `rst` asserted during STREAM of a 4×4 matrix after 5 transfers:
  - All outputs return to reset values asynchronously and `read_ready`=1.
  - A fresh request then streams all 16 elements.
- `read_request` pulsed mid-stream with a different ID: ignored; the current matrix completes unchanged.

Source files
------------

// File: rtl/matrix_storage_pkg.sv
// Shared definitions for the matrix storage slot layout and the reader FSM.
// The header layout is shared with matrix_writer, so both blocks must agree on it.
package matrix_storage_pkg;

    // Number of header words at the start of every slot
    localparam int HEADER_WORDS = 3;

    // Word offsets of the header fields inside a slot
    localparam int HDR_DIM_OFFSET     = 0;
    localparam int HDR_NAME_LO_OFFSET = 1;
    localparam int HDR_NAME_HI_OFFSET = 2;

    // Bit positions of the dimensions inside the dimension word
    localparam int ROWS_MSB = 15;
    localparam int ROWS_LSB = 8;
    localparam int COLS_MSB = 7;
    localparam int COLS_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CHECK,
        ST_STREAM,
        ST_DONE
    } reader_state_t;

    // Element count of a matrix; 8x8-bit operands always fit in 16 bits
    function automatic logic [15:0] header_total(input logic [7:0] rows, input logic [7:0] cols);
        return {8'b0, rows} * {8'b0, cols};
    endfunction

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry FIFO holding element words plus their last flag.
// Absorbs BRAM reads that are already in flight when downstream stalls.
module reader_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    // Pointer, storage and occupancy updates for push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // FIFO state registers; reset empties the FIFO and zeroes its storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/matrix_reader.sv
// Streams one stored matrix out of the storage BRAM: reads the 3-word header,
// validates the dimensions, then delivers the row-major payload on a
// valid/ready stream with a last marker.
module matrix_reader
    import matrix_storage_pkg::*;
#(
    parameter int BLOCK_SIZE = 1152,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_request,
    input  logic [2:0]            matrix_id,
    output logic                  read_ready,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [7:0]            actual_rows,
    output logic [7:0]            actual_cols,
    output logic [0:7][7:0]       matrix_name,
    output logic                  meta_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_last,
    output logic                  read_done,
    output logic                  error
);

    localparam logic [15:0] MAX_ELEMS = 16'(BLOCK_SIZE - HEADER_WORDS);

    reader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [15:0]           issue_idx_q, issue_idx_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [7:0]            rows_q, rows_d;
    logic [7:0]            cols_q, cols_d;
    logic [0:7][7:0]       name_q, name_d;
    logic                  meta_valid_q, meta_valid_d;
    logic                  error_q, error_d;

    logic [15:0]           total;
    logic [15:0]           last_idx;
    logic [15:0]           elem_idx;
    logic                  total_ok;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] elem_addr;
    logic [ADDR_WIDTH-1:0] hdr_offset;
    logic [DATA_WIDTH:0]   head_word;
    logic                  head_last;

    // Header validation, FIFO credit accounting and element address generation
    always_comb begin
        total      = header_total(rows_q, cols_q);
        last_idx   = total - 16'd1;
        total_ok   = (total != 16'd0) && (total <= MAX_ELEMS);
        fifo_empty = (fifo_count == 2'd0);
        pop        = !fifo_empty && data_ready;
        occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
        // The first element is issued from CHECK so the payload follows the header without a gap
        issue      = ((state_q == ST_CHECK) && total_ok) ||
                     ((state_q == ST_STREAM) && (issue_idx_q < total) && (occupancy < 3'd2));
        // Once everything is issued the address parks on the final element instead of running past it
        elem_idx   = (issue_idx_q < total) ? issue_idx_q : last_idx;
        elem_addr  = base_q + ADDR_WIDTH'(HEADER_WORDS) + ADDR_WIDTH'(elem_idx);
        hdr_offset = (hdr_cnt_q == 2'(HEADER_WORDS)) ? ADDR_WIDTH'(HEADER_WORDS - 1)
                                                     : ADDR_WIDTH'(hdr_cnt_q);
    end

    // Next-state logic, header capture and read address selection
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        hdr_cnt_d       = hdr_cnt_q;
        issue_idx_d     = issue ? issue_idx_q + 16'd1 : issue_idx_q;
        inflight_d      = issue;
        inflight_last_d = issue && (issue_idx_q == last_idx);
        rows_d          = rows_q;
        cols_d          = cols_q;
        name_d          = name_q;
        meta_valid_d    = meta_valid_q;
        error_d         = 1'b0;
        read_addr       = '0;

        case (state_q)
            ST_IDLE: begin
                if (read_request) begin
                    base_d       = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
                    hdr_cnt_d    = 2'd0;
                    issue_idx_d  = 16'd0;
                    meta_valid_d = 1'b0;
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                read_addr = base_q + hdr_offset;
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                if (hdr_cnt_q == 2'(HDR_DIM_OFFSET + 1)) begin
                    rows_d = bram_dout[ROWS_MSB:ROWS_LSB];
                    cols_d = bram_dout[COLS_MSB:COLS_LSB];
                end
                if (hdr_cnt_q == 2'(HDR_NAME_LO_OFFSET + 1)) begin
                    name_d[0:3] = bram_dout[31:0];
                end
                if (hdr_cnt_q == 2'(HDR_NAME_HI_OFFSET + 1)) begin
                    name_d[4:7] = bram_dout[31:0];
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                meta_valid_d = 1'b1;
                if (total_ok) begin
                    read_addr = elem_addr;
                    state_d   = ST_STREAM;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                read_addr = elem_addr;
                if (pop && head_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and header registers; reset aborts any transfer in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            hdr_cnt_q       <= 2'd0;
            issue_idx_q     <= 16'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rows_q          <= 8'd0;
            cols_q          <= 8'd0;
            name_q          <= '0;
            meta_valid_q    <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            hdr_cnt_q       <= hdr_cnt_d;
            issue_idx_q     <= issue_idx_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            rows_q          <= rows_d;
            cols_q          <= cols_d;
            name_q          <= name_d;
            meta_valid_q    <= meta_valid_d;
            error_q         <= error_d;
        end
    end

    reader_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, bram_dout}),
        .pop       (pop),
        .head_data (head_word),
        .count     (fifo_count)
    );

    assign head_last   = head_word[DATA_WIDTH];
    assign data_out    = head_word[DATA_WIDTH-1:0];
    assign data_valid  = !fifo_empty;
    assign data_last   = !fifo_empty && head_last;
    assign read_ready  = (state_q == ST_IDLE);
    assign read_done   = (state_q == ST_DONE);
    assign actual_rows = rows_q;
    assign actual_cols = cols_q;
    assign matrix_name = name_q;
    assign meta_valid  = meta_valid_q;
    assign error       = error_q;

endmodule

// File: tb/tb_matrix_reader.sv
// Self-checking bench for matrix_reader with a behavioural BRAM and an element scoreboard.
module tb_matrix_reader;

    localparam int BLOCK_SIZE = 1152;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 14;

    logic                  clk;
    logic                  rst;
    logic                  read_request;
    logic [2:0]            matrix_id;
    logic                  read_ready;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] bram_dout;
    logic [7:0]            actual_rows;
    logic [7:0]            actual_cols;
    logic [0:7][7:0]       matrix_name;
    logic                  meta_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  data_last;
    logic                  read_done;
    logic                  error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]            slot_rows [8];
    logic [7:0]            slot_cols [8];
    int                    slot_first [8];
    logic [DATA_WIDTH:0]   exp_q [$];

    int                    meta_rel, first_valid_rel, last_rel, done_rel, ready_rel, err_rel;
    int                    err_count, done_count, n_transfers;
    logic                  meta_at_start;
    logic [ADDR_WIDTH-1:0] max_addr;

    matrix_reader #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .read_request (read_request),
        .matrix_id    (matrix_id),
        .read_ready   (read_ready),
        .read_addr    (read_addr),
        .bram_dout    (bram_dout),
        .actual_rows  (actual_rows),
        .actual_cols  (actual_cols),
        .matrix_name  (matrix_name),
        .meta_valid   (meta_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_last    (data_last),
        .read_done    (read_done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time events relative to request acceptance
    always @(posedge clk) cyc <= cyc + 1;

    // Storage manager read port with one cycle of latency
    initial bram_dout = '0;
    always @(posedge clk) bram_dout <= mem[read_addr];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadMatrix(input int slot, input logic [7:0] rows, input logic [7:0] cols,
                              input logic [63:0] name, input int first);
        int base;
        int n;
        base = slot * BLOCK_SIZE;
        n    = int'(rows) * int'(cols);
        mem[base]     = {16'b0, rows, cols};
        mem[base + 1] = name[63:32];
        mem[base + 2] = name[31:0];
        if (n <= BLOCK_SIZE - 3) begin
            for (int k = 0; k < n; k++) mem[base + 3 + k] = DATA_WIDTH'(first + k);
        end
        slot_rows[slot]  = rows;
        slot_cols[slot]  = cols;
        slot_first[slot] = first;
    endtask

    // Pushes the expected payload of the slot, then pulses read_request for one edge
    task automatic applyStimulus(input logic [2:0] id);
        int n;
        n = int'(slot_rows[id]) * int'(slot_cols[id]);
        if (n != 0 && n <= BLOCK_SIZE - 3) begin
            for (int k = 0; k < n; k++)
                exp_q.push_back({1'(k == n - 1), DATA_WIDTH'(slot_first[id] + k)});
        end
        @(negedge clk);
        read_request = 1'b1;
        matrix_id    = id;
        @(negedge clk);
        read_request = 1'b0;
        e0 = cyc;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_read_ready"}, 64'(read_ready), 64'd1);
        checkOutput({pfx, "_read_addr"}, 64'(read_addr), 64'd0);
        checkOutput({pfx, "_meta_valid"}, 64'(meta_valid), 64'd0);
        checkOutput({pfx, "_data_valid"}, 64'(data_valid), 64'd0);
        checkOutput({pfx, "_data_last"}, 64'(data_last), 64'd0);
        checkOutput({pfx, "_read_done"}, 64'(read_done), 64'd0);
        checkOutput({pfx, "_error"}, 64'(error), 64'd0);
        checkOutput({pfx, "_rows"}, 64'(actual_rows), 64'd0);
        checkOutput({pfx, "_cols"}, 64'(actual_cols), 64'd0);
        checkOutput({pfx, "_name"}, 64'(matrix_name), 64'd0);
        checkOutput({pfx, "_data_out"}, 64'(data_out), 64'd0);
    endtask

    // Runs one read from the negedge after acceptance, consuming and scoring elements.
    // mode 0 keeps data_ready high, mode 1 drives the pattern 1,0,0 repeating.
    task automatic streamRead(input int mode, input int max_cycles, input int stop_after,
                              input int poke_rel, input logic [2:0] poke_id);
        logic                finished;
        logic                stall_pending;
        logic [DATA_WIDTH:0] stall_word;
        logic [DATA_WIDTH:0] exp_word;
        int                  rel;
        meta_rel = -1; first_valid_rel = -1; last_rel = -1; done_rel = -1;
        ready_rel = -1; err_rel = -1; err_count = 0; done_count = 0; n_transfers = 0;
        max_addr = '0; meta_at_start = 1'bx;
        finished = 1'b0; stall_pending = 1'b0; stall_word = '0;
        for (int i = 0; i < max_cycles; i++) begin
            rel = cyc - e0;
            if (rel == poke_rel) begin
                read_request = 1'b1;
                matrix_id    = poke_id;
            end else begin
                read_request = 1'b0;
            end
            data_ready = (mode == 0) ? 1'b1 : 1'((i % 3) == 0);
            #1;
            if (rel == 0) meta_at_start = meta_valid;
            if (!read_ready && read_addr > max_addr) max_addr = read_addr;
            if (meta_valid && meta_rel < 0) meta_rel = rel;
            if (error) begin
                err_count++;
                err_rel = rel;
            end
            if (data_valid && first_valid_rel < 0) first_valid_rel = rel;
            if (stall_pending) begin
                checkOutput("stall_valid", 64'(data_valid), 64'd1);
                checkOutput("stall_word", 64'({data_last, data_out}), 64'(stall_word));
            end
            if (data_valid && data_ready) begin
                checkOutput("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    checkOutput("sb_element", 64'({data_last, data_out}), 64'(exp_word));
                end
                n_transfers++;
                if (data_last) last_rel = rel;
            end
            stall_pending = data_valid && !data_ready;
            stall_word    = {data_last, data_out};
            if (read_done) begin
                done_count++;
                done_rel = rel;
            end
            if (rel > 0 && read_ready && (done_count > 0 || err_count > 0)) begin
                ready_rel = rel;
                finished  = 1'b1;
                break;
            end
            if (stop_after > 0 && n_transfers == stop_after) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        read_request = 1'b0;
        checkOutput("stream_timeout", 64'(finished), 64'd1);
    endtask

    initial begin
        rst          = 1'b1;
        read_request = 1'b0;
        matrix_id    = 3'd0;
        data_ready   = 1'b1;
        for (int a = 0; a < (1 << ADDR_WIDTH); a++) mem[a] = '0;
        for (int s = 0; s < 8; s++) begin
            slot_rows[s] = 8'd0; slot_cols[s] = 8'd0; slot_first[s] = 0;
        end
        loadMatrix(2, 8'd2, 8'd3, {"MATA", 32'h0}, 1);
        loadMatrix(0, 8'd0, 8'd5, {"ZERO", 32'h0}, 0);
        loadMatrix(7, 8'd34, 8'd34, "BIGMATRX", 0);
        loadMatrix(3, 8'd4, 8'd4, "QUADMTRX", 100);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        $display("[TB] reset values");
        checkResetValues("init");

        $display("[TB] slot 2 with data_ready high");
        applyStimulus(3'd2);
        streamRead(0, 60, 0, -1, 3'd0);
        checkOutput("t1_meta_rel", 64'(meta_rel), 64'd5);
        checkOutput("t1_rows", 64'(actual_rows), 64'd2);
        checkOutput("t1_cols", 64'(actual_cols), 64'd3);
        checkOutput("t1_name", 64'(matrix_name), {"MATA", 32'h0});
        checkOutput("t1_first_valid_rel", 64'(first_valid_rel), 64'd6);
        checkOutput("t1_last_rel", 64'(last_rel), 64'd11);
        checkOutput("t1_done_rel", 64'(done_rel), 64'd12);
        checkOutput("t1_done_count", 64'(done_count), 64'd1);
        checkOutput("t1_ready_rel", 64'(ready_rel), 64'd13);
        checkOutput("t1_transfers", 64'(n_transfers), 64'd6);
        checkOutput("t1_sb_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("t1_max_addr", 64'(max_addr), 64'(2 * BLOCK_SIZE + 8));
        checkOutput("t1_err_count", 64'(err_count), 64'd0);

        $display("[TB] slot 2 with backpressure");
        applyStimulus(3'd2);
        streamRead(1, 100, 0, -1, 3'd0);
        checkOutput("t2_meta_cleared", 64'(meta_at_start), 64'd0);
        checkOutput("t2_transfers", 64'(n_transfers), 64'd6);
        checkOutput("t2_sb_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("t2_max_addr", 64'(max_addr), 64'(2 * BLOCK_SIZE + 8));
        checkOutput("t2_done_count", 64'(done_count), 64'd1);
        data_ready = 1'b1;

        $display("[TB] slot 0 zero-row header");
        applyStimulus(3'd0);
        streamRead(0, 40, 0, -1, 3'd0);
        checkOutput("t3_err_rel", 64'(err_rel), 64'd5);
        checkOutput("t3_err_count", 64'(err_count), 64'd1);
        checkOutput("t3_no_valid", 64'(first_valid_rel), 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t3_ready_rel", 64'(ready_rel), 64'd5);
        checkOutput("t3_meta_valid", 64'(meta_valid), 64'd1);
        checkOutput("t3_cols", 64'(actual_cols), 64'd5);
        checkOutput("t3_max_addr", 64'(max_addr), 64'd2);
        checkOutput("t3_done_count", 64'(done_count), 64'd0);

        $display("[TB] slot 7 oversize header");
        applyStimulus(3'd7);
        streamRead(0, 40, 0, -1, 3'd0);
        checkOutput("t4_err_rel", 64'(err_rel), 64'd5);
        checkOutput("t4_err_count", 64'(err_count), 64'd1);
        checkOutput("t4_max_addr", 64'(max_addr), 64'(7 * BLOCK_SIZE + 2));
        checkOutput("t4_rows", 64'(actual_rows), 64'd34);
        checkOutput("t4_no_valid", 64'(first_valid_rel), 64'hFFFF_FFFF_FFFF_FFFF);

        $display("[TB] reset during stream of slot 3");
        applyStimulus(3'd3);
        streamRead(0, 60, 5, -1, 3'd0);
        checkOutput("t5_partial", 64'(n_transfers), 64'd5);
        @(posedge clk);
        #2;
        checkOutput("t5_pre_reset_valid", 64'(data_valid), 64'd1);
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_no_done", 64'(read_done), 64'd0);
        checkOutput("t5_ready", 64'(read_ready), 64'd1);
        applyStimulus(3'd3);
        streamRead(0, 80, 0, -1, 3'd0);
        checkOutput("t5_transfers", 64'(n_transfers), 64'd16);
        checkOutput("t5_done_rel", 64'(done_rel), 64'd22);
        checkOutput("t5_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] request with other ID during stream");
        applyStimulus(3'd2);
        streamRead(0, 60, 0, 8, 3'd5);
        checkOutput("t6_transfers", 64'(n_transfers), 64'd6);
        checkOutput("t6_done_rel", 64'(done_rel), 64'd12);
        checkOutput("t6_sb_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("t6_max_addr", 64'(max_addr), 64'(2 * BLOCK_SIZE + 8));
        repeat (3) @(negedge clk);
        checkOutput("t6_still_idle", 64'(read_ready), 64'd1);
        checkOutput("t6_rows_kept", 64'(actual_rows), 64'd2);
        checkOutput("t6_meta_kept", 64'(meta_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
